alu_exec_unit: RTL

//  Sequenced 8-bit ALU with accumulator Y and store register R. It sits upstream of

---
 rtl/alu_exec_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Sequenced 8-bit ALU with accumulator y and store register r, driving the display nibbles.
// Optional build macro ALU_UNDO_EN adds an undo input that restores {y, flags} from a shadow copy.
module alu_exec_unit #(
   parameter logic [7:0] RESET_Y = 8'h00,
   parameter logic [7:0] RESET_R = 8'h00
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] a,
   input  logic [3:0] sel,
   input  logic       go,
   input  logic       load,
`ifdef ALU_UNDO_EN
   input  logic       undo,
`endif
   output logic [7:0] y,
   output logic [3:0] upper_y,
   output logic [3:0] lower_y,
   output logic       carry,
   output logic       zero,
   output logic       neg,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, CAP, EXEC, WB} state_t;

   state_t     state, state_nxt;
   logic       go_q, load_q;
   logic       go_rise, load_rise;
   logic [7:0] opa, r;
   logic [3:0] opc;
   logic [8:0] res, alu_res;

   assign go_rise   = go & ~go_q;
   assign load_rise = load & ~load_q;
   assign upper_y   = y[7:4];
   assign lower_y   = y[3:0];

`ifdef ALU_UNDO_EN
   logic       undo_q, undo_rise, undo_v;
   logic [7:0] sh_y;
   logic       sh_c, sh_z, sh_n;
   assign undo_rise = undo & ~undo_q;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; load has priority over go in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!load_rise && go_rise) state_nxt = CAP;
         CAP:  state_nxt = EXEC;
         EXEC: state_nxt = WB;
         WB:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy = (state != IDLE);
      done = (state == WB);
   end

   // Bit 8 carries the carry/borrow flag for ops that define one, 0 otherwise
   always_comb begin
      alu_res = 9'd0;
      case (opc)
         4'd0:  alu_res = {1'b0, y} + {1'b0, opa};
         4'd1,
         4'd4:  alu_res = {1'b0, y} - {1'b0, opa};
         4'd2:  alu_res = {y[7], y[6:0], 1'b0};
         4'd3:  alu_res = {y[0], 1'b0, y[7:1]};
         4'd5:  alu_res = {1'b0, y & opa};
         4'd6:  alu_res = {1'b0, y | opa};
         4'd7:  alu_res = {1'b0, y ^ opa};
         4'd8:  alu_res = {1'b0, ~(y & opa)};
         4'd9:  alu_res = {1'b0, ~(y | opa)};
         4'd10: alu_res = {1'b0, ~(y ^ opa)};
         4'd11: alu_res = {1'b0, ~opa};
         4'd12: alu_res = {1'b0, ~y};
         4'd13: alu_res = {(y != 8'd0), 8'd0 - y};
         4'd14: alu_res = {1'b0, y};
         4'd15: alu_res = {1'b0, r};
         default: alu_res = 9'd0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         go_q   <= 1'b0;
         load_q <= 1'b0;
         opa    <= 8'd0;
         opc    <= 4'd0;
         res    <= 9'd0;
         y      <= RESET_Y;
         r      <= RESET_R;
         carry  <= 1'b0;
         zero   <= 1'b0;
         neg    <= 1'b0;
`ifdef ALU_UNDO_EN
         undo_q <= 1'b0;
         undo_v <= 1'b0;
         sh_y   <= 8'd0;
         sh_c   <= 1'b0;
         sh_z   <= 1'b0;
         sh_n   <= 1'b0;
`endif
      end else begin
         go_q   <= go;
         load_q <= load;
`ifdef ALU_UNDO_EN
         undo_q <= undo;
`endif
         case (state)
            IDLE: begin
               if (load_rise) begin
                  y    <= a;
                  zero <= (a == 8'd0);
                  neg  <= a[7];
`ifdef ALU_UNDO_EN
                  {sh_y, sh_c, sh_z, sh_n} <= {y, carry, zero, neg};
                  undo_v <= 1'b1;
`endif
               end else if (go_rise) begin
                  opa <= a;
                  opc <= sel;
               end
`ifdef ALU_UNDO_EN
               else if (undo_rise && undo_v) begin
                  {y, carry, zero, neg} <= {sh_y, sh_c, sh_z, sh_n};
                  undo_v <= 1'b0;
               end
`endif
            end
            EXEC: res <= alu_res;
            WB: begin
`ifdef ALU_UNDO_EN
               {sh_y, sh_c, sh_z, sh_n} <= {y, carry, zero, neg};
               undo_v <= 1'b1;
`endif
               case (opc)
                  4'd14: r <= y;
                  4'd4: begin
                     carry <= res[8];
                     zero  <= (res[7:0] == 8'd0);
                     neg   <= res[7];
                  end
                  default: begin
                     if (opc == 4'd15) r <= y;
                     y     <= res[7:0];
                     carry <= res[8];
                     zero  <= (res[7:0] == 8'd0);
                     neg   <= res[7];
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
